clk_monitor: RTL and testbench

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_mon_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/clk_monitor.sv | 149 ++++++++++++++
 tb/tb_clk_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared FSM state type and default parameter values for the clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } mon_state_t;

    localparam int DEFAULT_TIMEOUT      = 65535;
    localparam int DEFAULT_EXPECTED_DIV = 12;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one edge flop; rise/fall are one-cycle pulses.
// Latency: a clk_in transition is acted on by the consumer 3 clk_12mhz edges later; no backpressure.
module sync_edge_det (
    input  logic clk_12mhz,
    input  logic rst,
    input  logic clk_in,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic edge_q;

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q1 <= clk_in;
            sync_q2 <= sync_q1;
            edge_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~edge_q;
    assign fall = ~sync_q2 & edge_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures clk_in high/low/period in clk_12mhz cycles and flags stalls; CLK_MON_EXPECT_CHECK_EN adds mismatch.
// Latency: results one cycle after the closing rising edge is detected; no backpressure, meas_valid is a pulse.
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    parameter int EXPECTED_DIV = DEFAULT_EXPECTED_DIV
) (
    input  logic             clk_12mhz,
    input  logic             rst,
    input  logic             clk_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W:0]   period_cycles,
    output logic             meas_valid,
    output logic             stalled
`ifdef CLK_MON_EXPECT_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam longint CNT_LIMIT = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    // Reject configurations where the stall threshold can never be reached.
    if (TIMEOUT < 1 || longint'(TIMEOUT) > CNT_LIMIT || EXPECTED_DIV < 1) begin : g_bad_params
        $error("clk_monitor: TIMEOUT must be 1..2^CNT_W-1 and EXPECTED_DIV >= 1");
    end

    logic rise;
    logic fall;

    sync_edge_det u_sync_edge_det (
        .clk_12mhz (clk_12mhz),
        .rst       (rst),
        .clk_in    (clk_in),
        .rise      (rise),
        .fall      (fall)
    );

    mon_state_t       state;
    mon_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W-1:0] high_lat_nxt;
    logic [CNT_W:0]   period_sum;
    logic             at_timeout;
    logic             publish;
    logic             stall_set;
    logic             stall_clr;

    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign at_timeout = (cnt == TIMEOUT_CNT);
    assign period_sum = {1'b0, high_lat} + {1'b0, cnt};

    // An edge arriving in the timeout cycle takes priority over the stall.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        high_lat_nxt = high_lat;
        publish      = 1'b0;
        stall_set    = 1'b0;
        stall_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_ONE;
                    stall_clr = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    high_lat_nxt = cnt;
                    cnt_nxt      = CNT_ONE;
                    state_nxt    = LOW;
                end else if (at_timeout) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    stall_set = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    publish   = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = HIGH;
                end else if (at_timeout) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    stall_set = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            high_lat      <= '0;
            high_cycles   <= '0;
            low_cycles    <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            high_lat   <= high_lat_nxt;
            meas_valid <= publish;
            if (publish) begin
                high_cycles   <= high_lat;
                low_cycles    <= cnt;
                period_cycles <= period_sum;
            end
            if (stall_set) begin
                stalled <= 1'b1;
            end else if (stall_clr) begin
                stalled <= 1'b0;
            end
        end
    end

`ifdef CLK_MON_EXPECT_CHECK_EN
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (publish) begin
            mismatch <= (period_sum != (CNT_W+1)'(EXPECTED_DIV));
        end
    end
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: two instances (TIMEOUT 100 and 6) share clk_in and are checked against a segment-length model.
module tb_clk_monitor;

    localparam int CNT_W   = 16;
    localparam int NDUT    = 2;
    localparam int TOUT_A  = 100;
    localparam int TOUT_B  = 6;
    localparam int EXP_DIV = 12;

    logic clk_12mhz = 1'b0;
    logic rst;
    logic clk_in;

    always #5 clk_12mhz = ~clk_12mhz;

    logic [CNT_W-1:0] high_a, low_a, high_b, low_b;
    logic [CNT_W:0]   per_a, per_b;
    logic             mv_a, mv_b, st_a, st_b;
`ifdef CLK_MON_EXPECT_CHECK_EN
    logic             mm_a, mm_b;
`endif

    clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TOUT_A), .EXPECTED_DIV(EXP_DIV)) dut_a (
        .clk_12mhz     (clk_12mhz),
        .rst           (rst),
        .clk_in        (clk_in),
        .high_cycles   (high_a),
        .low_cycles    (low_a),
        .period_cycles (per_a),
        .meas_valid    (mv_a),
        .stalled       (st_a)
`ifdef CLK_MON_EXPECT_CHECK_EN
        ,
        .mismatch      (mm_a)
`endif
    );

    clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TOUT_B), .EXPECTED_DIV(EXP_DIV)) dut_b (
        .clk_12mhz     (clk_12mhz),
        .rst           (rst),
        .clk_in        (clk_in),
        .high_cycles   (high_b),
        .low_cycles    (low_b),
        .period_cycles (per_b),
        .meas_valid    (mv_b),
        .stalled       (st_b)
`ifdef CLK_MON_EXPECT_CHECK_EN
        ,
        .mismatch      (mm_b)
`endif
    );

    typedef struct {
        int hi;
        int lo;
        int exp_high;
        int exp_low;
        int exp_period;
        bit exp_mm;
    } vec_t;

    // Reference model: lengths of detected level segments, per instance.
    int  tout      [NDUT];
    bit  m_track   [NDUT];
    bit  m_have_hi [NDUT];
    bit  m_stall   [NDUT];
    bit  m_mv      [NDUT];
    bit  m_mm      [NDUT];
    int  m_last    [NDUT];
    int  m_hi      [NDUT];
    int  m_high    [NDUT];
    int  m_low     [NDUT];
    bit  lvl_hist  [0:131071];
    int  cyc;
    int  n_tests;
    int  n_fail;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_track[i] = 0; m_have_hi[i] = 0; m_stall[i] = 0; m_mv[i] = 0; m_mm[i] = 0;
            m_last[i] = 0; m_hi[i] = 0; m_high[i] = 0; m_low[i] = 0;
        end
    endtask

    // A level driven in cycle k is seen as an edge by the monitor at edge k+3.
    task automatic model_step();
        bit r, f;
        r = 0;
        f = 0;
        if (cyc >= 4) begin
            r = lvl_hist[cyc-3] && !lvl_hist[cyc-4];
            f = !lvl_hist[cyc-3] && lvl_hist[cyc-4];
        end
        for (int i = 0; i < NDUT; i++) begin
            m_mv[i] = 0;
            if (!m_track[i]) begin
                if (r) begin
                    m_track[i] = 1; m_have_hi[i] = 0; m_last[i] = cyc; m_stall[i] = 0;
                end
            end else if (r && m_have_hi[i]) begin
                m_high[i] = m_hi[i];
                m_low[i]  = cyc - m_last[i];
                m_mv[i]   = 1;
                m_mm[i]   = (m_high[i] + m_low[i] != EXP_DIV);
                m_have_hi[i] = 0;
                m_last[i] = cyc;
            end else if (f && !m_have_hi[i]) begin
                m_hi[i] = cyc - m_last[i];
                m_have_hi[i] = 1;
                m_last[i] = cyc;
            end else if (cyc - m_last[i] >= tout[i]) begin
                m_stall[i] = 1;
                m_track[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("a_high",   high_a, m_high[0]);
        check("a_low",    low_a,  m_low[0]);
        check("a_period", per_a,  m_high[0] + m_low[0]);
        check("a_valid",  mv_a,   m_mv[0]);
        check("a_stall",  st_a,   m_stall[0]);
        check("b_high",   high_b, m_high[1]);
        check("b_low",    low_b,  m_low[1]);
        check("b_period", per_b,  m_high[1] + m_low[1]);
        check("b_valid",  mv_b,   m_mv[1]);
        check("b_stall",  st_b,   m_stall[1]);
`ifdef CLK_MON_EXPECT_CHECK_EN
        check("a_mismatch", mm_a, m_mm[0]);
        check("b_mismatch", mm_b, m_mm[1]);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_outputs"}, {high_a, low_a, per_a, mv_a, st_a}, 0);
        check({tag, "_b_outputs"}, {high_b, low_b, per_b, mv_b, st_b}, 0);
`ifdef CLK_MON_EXPECT_CHECK_EN
        check({tag, "_mismatch"}, {mm_a, mm_b}, 0);
`endif
    endtask

    task automatic step(input logic v);
        @(posedge clk_12mhz);
        #1;
        cyc++;
        model_step();
        compare_all();
        clk_in = v;
        lvl_hist[cyc] = v;
    endtask

    task automatic period(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk_12mhz);
        #1;
        cyc++;
        compare_all();
        lvl_hist[cyc] = clk_in;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   first_n;
        int   clr_n;
        int   cnt_mv;
        bit   st_seen;
        logic lv;

        vecs[0] = '{hi: 6,  lo: 6,  exp_high: 6,  exp_low: 6,  exp_period: 12, exp_mm: 0};
        vecs[1] = '{hi: 3,  lo: 6,  exp_high: 3,  exp_low: 6,  exp_period: 9,  exp_mm: 1};
        vecs[2] = '{hi: 1,  lo: 1,  exp_high: 1,  exp_low: 1,  exp_period: 2,  exp_mm: 1};
        vecs[3] = '{hi: 20, lo: 5,  exp_high: 20, exp_low: 5,  exp_period: 25, exp_mm: 1};
        vecs[4] = '{hi: 2,  lo: 13, exp_high: 2,  exp_low: 13, exp_period: 15, exp_mm: 1};

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        tout[0] = TOUT_A;
        tout[1] = TOUT_B;
        model_reset();
        rst    = 1'b1;
        clk_in = 1'b0;
        repeat (3) @(posedge clk_12mhz);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        // Table: three periods of each shape, then a closing rise; last publication must match.
        for (int v = 0; v < 5; v++) begin
            repeat (3) period(vecs[v].hi, vecs[v].lo);
            step(1'b1);
            repeat (5) step(1'b0);
            check("vec_high",   high_a, vecs[v].exp_high);
            check("vec_low",    low_a,  vecs[v].exp_low);
            check("vec_period", per_a,  vecs[v].exp_period);
`ifdef CLK_MON_EXPECT_CHECK_EN
            check("vec_mismatch", mm_a, vecs[v].exp_mm);
`endif
        end

        // Stall: hold low 150 cycles after a valid 6/6 clock.
        repeat (3) period(6, 6);
        repeat (6) step(1'b1);
        cnt_mv = 0;
        repeat (150) begin
            step(1'b0);
            cnt_mv += mv_a;
        end
        check("stall_no_valid", cnt_mv, 0);
        check("stall_level", st_a, 1);

        // Resume: stall clears when the first rise is detected, first result a full period later.
        first_n = -1;
        clr_n   = -1;
        for (int n = 1; n <= 40; n++) begin
            step(((n - 1) % 12) < 6);
            if (clr_n < 0 && !st_a) clr_n = n;
            if (first_n < 0 && mv_a) first_n = n;
        end
        check("resume_stall_clear_step", clr_n, 4);
        check("resume_first_valid_step", first_n, 16);

        // Reset in the middle of a low phase discards the partial period.
        repeat (6) step(1'b1);
        repeat (4) step(1'b0);
        pulse_reset();
        step(1'b0);
        first_n = -1;
        for (int n = 1; n <= 40; n++) begin
            step(((n - 1) % 12) < 6);
            if (first_n < 0 && mv_a) first_n = n;
        end
        check("post_reset_first_valid_step", first_n, 16);

        // Edge coinciding with TIMEOUT=6 wins: no stall, one result per period.
        repeat (2) period(6, 6);
        cnt_mv  = 0;
        st_seen = 0;
        repeat (5) begin
            for (int n = 0; n < 12; n++) begin
                step(n < 6);
                cnt_mv += mv_b;
                st_seen |= st_b;
            end
        end
        check("boundary_b_no_stall", st_seen, 0);
        check("boundary_b_valid_count", cnt_mv, 5);
        check("boundary_b_high", high_b, 6);

        // One cycle beyond the threshold stalls every half period.
        cnt_mv = 0;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 14; n++) begin
                step(n < 7);
                if (p > 0) cnt_mv += mv_b;
            end
        end
        check("over_b_no_valid", cnt_mv, 0);
        check("over_b_stalled", st_b, 1);

        // Random segment lengths, occasionally straddling the 100-cycle timeout.
        lv = clk_in;
        for (int s = 0; s < 300; s++) begin
            int len;
            lv  = ~lv;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(95, 110) : $urandom_range(1, 20);
            repeat (len) step(lv);
        end
        repeat (20) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
